// File: rtl/rom_reader_pkg.sv
// Shared definitions for the 556PT5/556PT4 ROM dump sequencer: state encoding,
// chip operation codes and chip geometry constants.
package rom_reader_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_HANDOFF = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SETUP   = ST_SETUP,
    S_WAIT    = ST_WAIT,
    S_CAPTURE = ST_CAPTURE,
    S_HANDOFF = ST_HANDOFF,
    S_DONE    = ST_DONE
  } state_t;

  // Control lines V1..V4, bit0 = V1
  localparam logic [3:0] OP_IDLE = 4'b0000;
  localparam logic [3:0] OP_READ = 4'b1100;

  localparam int DATA_WIDTH_3604    = 8;
  localparam int ADDRESS_WIDTH_3604 = 9;
  localparam int DATA_WIDTH_3601    = 4;
  localparam int ADDRESS_WIDTH_3601 = 8;

endpackage

// File: rtl/rom_dump_sequencer_if.sv
// Downstream word stream of the ROM dump sequencer (address/data pairs).
interface rom_dump_sequencer_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
);
  // A word transfers on a rising edge where out_valid && out_ready. Once raised,
  // out_valid and out_addr/out_data hold until that transfer (abort/reset excepted);
  // out_ready may change freely and never depends combinationally on out_valid.
  logic [ADDRESS_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output out_addr, output out_data, output out_valid, input out_ready);
  modport slave  (input out_addr, input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/rom_access_timer.sv
// Access-time down counter: load ACCESS_CYCLES-1, decrement to zero, flag zero.
module rom_access_timer #(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(ACCESS_CYCLES - 1);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/rom_dump_sequencer.sv
// Full-chip read sweep of a 556PT5/556PT4 ROM, streaming (address, data) words downstream.
// Optional running checksum output enabled by defining ROM_DUMP_CHECKSUM_EN.
module rom_dump_sequencer
  import rom_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [3:0]               operation,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  rom_dump_sequencer_if.master     out_if,
  output logic                     busy,
  output logic                     done,
`ifdef ROM_DUMP_CHECKSUM_EN
  output logic [15:0]              checksum,
`endif
  output state_t                   state_dbg
);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = '1;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0]    out_data_q;
  logic                     out_valid_q;
  logic                     timer_load, timer_dec, timer_zero;
  logic                     abort_hit, start_hit, accept_hit;

  // abort beats both start and out_ready in the same cycle
  assign abort_hit  = abort && (state != S_IDLE);
  assign start_hit  = (state == S_IDLE) && start && !abort;
  assign accept_hit = (state == S_HANDOFF) && out_if.out_ready && !abort;

  rom_access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .dec   (timer_dec),
    .zero  (timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    operation  = OP_READ;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        operation = OP_IDLE;
        busy      = 1'b0;
        if (start_hit) state_next = S_SETUP;
      end
      S_SETUP: begin
        timer_load = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (timer_zero) state_next = S_CAPTURE;
        else            timer_dec  = 1'b1;
      end
      S_CAPTURE: state_next = S_HANDOFF;
      S_HANDOFF: begin
        if (accept_hit) state_next = (addr_q == ADDR_MAX) ? S_DONE : S_SETUP;
      end
      S_DONE: begin
        operation  = OP_IDLE;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort_hit) begin
      state_next = S_IDLE;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (abort_hit) begin
      addr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (start_hit) addr_q <= '0;
      if (state == S_CAPTURE) begin
        out_data_q  <= data_line_in;
        out_addr_q  <= addr_q;
        out_valid_q <= 1'b1;
      end
      // The last accepted word parks the address back at zero for DONE
      if (accept_hit) begin
        out_valid_q <= 1'b0;
        addr_q      <= (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
      end
    end
  end

`ifdef ROM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           checksum <= 16'h0000;
    else if (start_hit)  checksum <= 16'h0000;
    else if (accept_hit) checksum <= checksum + 16'(out_data_q);
  end
`endif

  assign address_line     = addr_q;
  assign out_if.out_addr  = out_addr_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_rom_dump_sequencer.sv
// Bench for rom_dump_sequencer (3-bit address, 8-bit data, 2 access cycles, ROM data = addr ^ 8'hA5).
module tb_rom_dump_sequencer;
  import rom_reader_pkg::*;

  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int ACC = 2;
  localparam logic [AW-1:0] ADDR_MAX = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] data_line_in;
  logic [3:0]    operation;
  logic [AW-1:0] address_line;
  logic          busy, done;
  state_t        state_dbg;
`ifdef ROM_DUMP_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  rom_dump_sequencer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) out_if ();
  assign out_if.out_ready = out_ready;

  // ROM chip: each word holds its address XOR 8'hA5
  assign data_line_in = 8'(address_line) ^ 8'hA5;

  rom_dump_sequencer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ACCESS_CYCLES(ACC)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .data_line_in (data_line_in),
    .operation    (operation),
    .address_line (address_line),
    .out_if       (out_if),
    .busy         (busy),
    .done         (done),
`ifdef ROM_DUMP_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sweep-level view: an address is presented, the word appears ACC+2 edges later,
  // it is held until accepted, then the next address follows; after the top word a done cycle.
  logic          m_active, m_done, m_valid;
  logic [AW-1:0] m_addr, m_out_addr;
  logic [DW-1:0] m_out_data;
  logic [15:0]   m_sum;
  int            m_wait;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_done <= 1'b0; m_valid <= 1'b0;
      m_addr <= '0; m_out_addr <= '0; m_out_data <= '0; m_sum <= '0; m_wait <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_active && abort) begin
      m_active <= 1'b0; m_valid <= 1'b0; m_addr <= '0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active <= 1'b1; m_addr <= '0; m_wait <= ACC + 2; m_sum <= '0;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_sum   <= m_sum + 16'(m_out_data);
        if (m_addr == ADDR_MAX) begin
          m_active <= 1'b0; m_done <= 1'b1; m_addr <= '0;
        end else begin
          m_addr <= m_addr + 3'd1; m_wait <= ACC + 2;
        end
      end
    end else begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid    <= 1'b1;
        m_out_addr <= m_addr;
        m_out_data <= 8'(m_addr) ^ 8'hA5;
      end
    end
  end

  // ---------------- compare + monitor (negative edge) ----------------
  logic [AW+DW-1:0] got_q[$];
  logic [AW+DW-1:0] exp_q[$];
  int rise_q[$];
  int cyc = 0;
  int done_cnt = 0;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      check("busy", 32'(busy), 32'(m_active | m_done));
      check("done", 32'(done), 32'(m_done));
      check("operation", 32'(operation), m_active ? 32'hC : 32'h0);
      check("address_line", 32'(address_line), 32'(m_addr));
      check("out_valid", 32'(out_if.out_valid), 32'(m_valid));
      if (m_valid) begin
        check("out_addr", 32'(out_if.out_addr), 32'(m_out_addr));
        check("out_data", 32'(out_if.out_data), 32'(m_out_data));
      end
`ifdef ROM_DUMP_CHECKSUM_EN
      check("checksum", 32'(checksum), 32'(m_sum));
`endif
      if (out_if.out_valid && out_ready) got_q.push_back({out_if.out_addr, out_if.out_data});
      if (out_if.out_valid && !valid_prev) rise_q.push_back(cyc);
      if (done) done_cnt++;
      valid_prev = out_if.out_valid;
    end else begin
      valid_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(1); n++; end
    check("wait_idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input int budget);
    int n = 0;
    while (address_line != a && n < budget) begin step(1); n++; end
    check("wait_addr_timeout", 32'(address_line), 32'(a));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_if.out_valid && n < budget) begin step(1); n++; end
    check("wait_valid_timeout", 32'(out_if.out_valid), 32'h1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_operation"}, 32'(operation), 32'h0);
    check({tag, "_out_valid"}, 32'(out_if.out_valid), 32'h0);
    check({tag, "_address_line"}, 32'(address_line), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] rom_tbl [8];
    logic [AW+DW-1:0] e, g;
    int n;
    rom_tbl = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2};

    // reset values
    step(3);
    check_idle_outputs("reset");
    check("reset_out_addr", 32'(out_if.out_addr), 32'h0);
    check("reset_out_data", 32'(out_if.out_data), 32'h0);
    reset = 1'b0;
    step(2);
    check_idle_outputs("post_reset");

    // 1: full sweep with out_ready high
    out_ready = 1'b1;
    got_q.delete(); rise_q.delete(); exp_q.delete(); done_cnt = 0;
    pulse_start();
    wait_idle(200);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), rom_tbl[i]});
    check("sweep_word_count", 32'(got_q.size()), 32'd8);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check("sweep_word", 32'(g), 32'(e));
    end
    check("sweep_rise_count", 32'(rise_q.size()), 32'd8);
    for (int i = 1; i < rise_q.size(); i++)
      check("sweep_period", 32'(rise_q[i] - rise_q[i-1]), 32'd5);
    check("sweep_done_pulses", 32'(done_cnt), 32'd1);
    check_idle_outputs("sweep_end");
`ifdef ROM_DUMP_CHECKSUM_EN
    check("sweep_checksum", 32'(checksum), 32'h051C);
`endif

    // 2: backpressure at address 3
    got_q.delete();
    pulse_start();
`ifdef ROM_DUMP_CHECKSUM_EN
    check("restart_checksum_clear", 32'(checksum), 32'h0);
`endif
    wait_addr(3'd3, 100);
    out_ready = 1'b0;
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(out_if.out_valid), 32'h1);
      check("hold_out_addr", 32'(out_if.out_addr), 32'h3);
      check("hold_out_data", 32'(out_if.out_data), 32'hA6);
      check("hold_address_line", 32'(address_line), 32'h3);
      step(1);
    end
    out_ready = 1'b1;
    n = 0;
    while (!(out_if.out_valid && out_if.out_addr == 3'd4) && n < 20) begin step(1); n++; end
    check("resume_addr4", 32'(out_if.out_addr), 32'h4);
    check("resume_data4", 32'(out_if.out_data), 32'hA1);
    wait_idle(200);
    check("bp_word_count", 32'(got_q.size()), 32'd8);

    // 3: abort in WAIT at address 5
    done_cnt = 0;
    pulse_start();
    wait_addr(3'd5, 100);
    step(1);
    check("abort_in_wait", 32'(state_dbg), 32'(S_WAIT));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_idle_outputs("abort");
    step(5);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    pulse_start();
    wait_valid(20);
    check("restart_addr", 32'(out_if.out_addr), 32'h0);
    check("restart_data", 32'(out_if.out_data), 32'hA5);
    wait_idle(200);

    // 4: async reset in HANDOFF, between edges
    out_ready = 1'b0;
    pulse_start();
    wait_valid(20);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_out_addr", 32'(out_if.out_addr), 32'h0);
    check("async_reset_out_data", 32'(out_if.out_data), 32'h0);
`ifdef ROM_DUMP_CHECKSUM_EN
    check("async_reset_checksum", 32'(checksum), 32'h0);
`endif
    step(1);
    reset = 1'b0;
    out_ready = 1'b1;
    step(2);
    check_idle_outputs("after_reset");

    // 5: start while busy is ignored; start+abort together lets abort win
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      step(7);
      pulse_start();
    end
    wait_idle(200);
    check("busy_start_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size(); i++)
      check("busy_start_order", 32'(got_q[i][DW +: AW]), 32'(i));
    pulse_start();
    step(6);
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    check_idle_outputs("start_abort_busy");
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    step(1);
    check_idle_outputs("start_abort_idle");

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 9) == 0);
      step(1);
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    wait_idle(200);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
